// File: rtl/db_multi_pkg.sv
// Shared types for the multi-channel debouncer: per-channel FSM state encoding.
package db_multi_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } db_state_e;

endpackage

// File: rtl/db_multi_chan.sv
// One debounce channel: input synchroniser, confirm FSM with sample counter,
// registered debounced level and one-cycle rise/fall pulses.
module db_multi_chan
    import db_multi_pkg::*;
#(
    parameter int N_SAMPLES   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw,
    input  logic       m_tick,
    output logic       db,
    output logic       db_rise,
    output logic       db_fall,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sw_s;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   confirm;

    assign sw_s    = sync_q[SYNC_STAGES-1];
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign confirm = (cnt_inc == CNT_W'(N_SAMPLES));

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sw};
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // In the WAIT states an abort takes priority over a coincident tick.
        case (state_q)
            ST_ZERO: begin
                if (sw_s) begin
                    state_d = ST_WAIT1;
                    cnt_d   = '0;
                end
            end
            ST_WAIT1: begin
                if (!sw_s) begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                end else if (m_tick) begin
                    if (confirm) begin
                        state_d = ST_ONE;
                        cnt_d   = '0;
                        db_d    = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_ONE: begin
                if (!sw_s) begin
                    state_d = ST_WAIT0;
                    cnt_d   = '0;
                end
            end
            ST_WAIT0: begin
                if (sw_s) begin
                    state_d = ST_ONE;
                    cnt_d   = '0;
                end else if (m_tick) begin
                    if (confirm) begin
                        state_d = ST_ZERO;
                        cnt_d   = '0;
                        db_d    = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_ZERO;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= ST_ZERO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db        = db_q;
    assign db_rise   = rise_q;
    assign db_fall   = fall_q;
    assign dbg_state = state_q;

endmodule

// File: rtl/db_multi.sv
// N-channel switch debouncer: one shared free-running sample tick feeding
// independent per-channel debounce FSMs.
module db_multi
    import db_multi_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TICK_BITS   = 20,
    parameter int N_SAMPLES   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   sw,
    output logic [N_CH-1:0]   db,
    output logic [N_CH-1:0]   db_rise,
    output logic [N_CH-1:0]   db_fall,
    output logic              dbg_tick,
    output logic [2*N_CH-1:0] dbg_state
);

    logic [TICK_BITS-1:0] tick_cnt_q, tick_cnt_d;
    logic                 m_tick;

    // Tick fires on the all-ones count, so the first one lands
    // 2^TICK_BITS-1 cycles after reset release.
    assign m_tick   = &tick_cnt_q;
    assign dbg_tick = m_tick;

    always_comb begin
        tick_cnt_d = tick_cnt_q + TICK_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        db_multi_chan #(
            .N_SAMPLES  (N_SAMPLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .sw       (sw[i]),
            .m_tick   (m_tick),
            .db       (db[i]),
            .db_rise  (db_rise[i]),
            .db_fall  (db_fall[i]),
            .dbg_state(dbg_state[2*i +: 2])
        );
    end

endmodule
